// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin packet arbiter sharing one UDP tx channel between two sources, with inter-packet gap and tx_done watchdog
module udp_tx_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [15:0] req0_byte_num,
  input  logic [15:0] req1_byte_num,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  output logic        req0_grant,
  output logic        req1_grant,
  output logic        req0_rd,
  output logic        req1_rd,
  output logic        req0_done,
  output logic        req1_done,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        tx_err,
  output logic        arb_busy,
  output logic        arb_owner
);
  localparam int CW = $clog2((TIMEOUT_CYCLES > IFG_CYCLES ? TIMEOUT_CYCLES : IFG_CYCLES) + 1);
  typedef enum logic [2:0] {IDLE, START, BUSY, DONE, GAP} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, ptr_q, ptr_d, zero_q, zero_d, err_q, err_d;
  logic [15:0] len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sel, grant, busy_rd;
  assign sel = (req0_valid & req1_valid) ? ptr_q : req1_valid;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d = ptr_q;
    zero_d = zero_q;
    err_d = err_q;
    len_d = len_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (req0_valid | req1_valid) begin
        owner_d = sel;
        len_d = sel ? req1_byte_num : req0_byte_num;
        zero_d = len_d == '0;
        err_d = 1'b0;
        state_d = zero_d ? DONE : START;
      end
      START: begin
        ptr_d = ~owner_q;
        cnt_d = '0;
        state_d = tx_done ? DONE : BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        err_d = !tx_done && cnt_q == CW'(TIMEOUT_CYCLES - 2);
        state_d = (tx_done || err_d) ? DONE : BUSY;
      end
      DONE: begin
        ptr_d = zero_q ? ~owner_q : ptr_q;
        cnt_d = '0;
        state_d = GAP;
      end
      GAP: begin
        cnt_d = cnt_q + CW'(1);
        state_d = cnt_q == CW'(IFG_CYCLES - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      ptr_q <= 1'b0;
      zero_q <= 1'b0;
      err_q <= 1'b0;
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q <= ptr_d;
      zero_q <= zero_d;
      err_q <= err_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
    end
  end
  assign grant = state_q == START || (state_q == DONE && zero_q);
  assign busy_rd = state_q == BUSY && tx_req;
  assign req0_grant = grant & ~owner_q;
  assign req1_grant = grant & owner_q;
  assign req0_rd = busy_rd & ~owner_q;
  assign req1_rd = busy_rd & owner_q;
  assign req0_done = state_q == DONE && !owner_q;
  assign req1_done = state_q == DONE && owner_q;
  assign tx_err = state_q == DONE && err_q;
  assign tx_start_en = state_q == START;
  assign tx_byte_num = len_q;
  assign tx_data = state_q == BUSY ? (owner_q ? req1_data : req0_data) : '0;
  assign arb_busy = state_q != IDLE;
  assign arb_owner = owner_q;
endmodule
